fir_frame_ctrl: RTL and testbench
=================================

FIR_FRAME_CTRL -- requirements
Module: fir_frame_ctrl

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 1024: input samples per frame.
REQ-002 SHALL have parameter TAPS, default 32: FIR tap count.
REQ-003 SHALL have parameter DW, default 16: sample width. Parameter OW, default 32: FIR result width.
REQ-004 Port clk: input, 1 bit. Single clock; all state updates on its rising edge.
REQ-005 Port rst: input, 1 bit. Reset is synchronous and active-low.
REQ-006 Port start: input, 1 bit. Pulse that begins a frame.
REQ-007 Port in_data: input, DW bits, signed. Source sample.
REQ-008 Port in_valid: input, 1 bit. Source sample valid.
REQ-009 Port in_ready: output, 1 bit. Controller accepts a sample.
REQ-010 Port fir_data: output, DW bits, signed. Sample to the FIR shift register.
REQ-011 Port fir_en: output, 1 bit. FIR shift enable; the datapath shifts only when this is 1.
REQ-012 Port fir_d: input, OW bits, signed. FIR combinational sum.
REQ-013 Port out_data: output, OW bits, signed. Registered filter result.
REQ-014 Port out_valid: output, 1 bit. out_data valid.
REQ-015 Port busy: output, 1 bit. Frame in progress.
REQ-016 Port frame_done: output, 1 bit. One-cycle end-of-frame pulse.

Function
REQ-017 SHALL implement states IDLE, LOAD, FLUSH, DONE. busy = (state != IDLE).
REQ-018 IDLE: in_ready=0, fir_en=0. start=1 moves the state to LOAD. start SHALL be ignored in every other state.
REQ-019 LOAD: in_ready=1, fir_data=in_data, fir_en=in_valid. The sample counter increments on each handshake (in_valid & in_ready). The FRAME_LEN-th handshake moves the state to FLUSH.
REQ-020 FLUSH: in_ready=0, fir_en=1 every cycle, fir_data=0. Lasts exactly TAPS cycles, then the state moves to DONE.
REQ-021 DONE: frame_done=1 for exactly one cycle, then the state moves to IDLE.
REQ-022 emit flag = fir_en & (LOAD | (FLUSH & flush_cnt < TAPS-1)).
REQ-023 A shift in cycle t SHALL produce out_valid=1 in cycle t+2, with out_data = fir_d sampled in cycle t+1 (latency 2).
REQ-024 Each frame SHALL emit exactly FRAME_LEN+TAPS-1 out_valid pulses, in order.
REQ-025 The final FLUSH shift is not emitted. Its purpose is to leave the FIR register all-zero for the next frame.
REQ-026 Gaps in in_valid during LOAD SHALL stall the FIR (no shift, no output) without changing results.
REQ-027 frame_done SHALL coincide with the last out_valid of the frame.
REQ-028 start asserted in the cycle after DONE (state IDLE) SHALL begin a new frame with no dead cycle beyond IDLE.
REQ-029 Counters SHALL be $clog2 wide for their range and SHALL return to 0 on leaving their state. Wrap-around SHALL never occur.
REQ-030 No output backpressure. The downstream SHALL accept every out_valid.

Reset
REQ-031 rst=0 at a clk edge SHALL force: state=IDLE, both counters=0, out_data=0, out_valid=0, frame_done=0, pipeline flags=0.
REQ-032 in_ready and fir_en SHALL therefore be 0 in the cycle after that edge.
REQ-033 Reset mid-frame SHALL abandon the frame with no further out_valid. The FIR datapath shares rst and is cleared by it.

Structure
REQ-034 A shared package fir_pkg SHALL hold: the state encoding, TAPS/FRAME_LEN/DW/OW defaults, and the 32-entry coefficient constant table used by the FIR datapath.
REQ-035 Sample and flush counts SHALL use one sub-module, the team's counter block (counter), instantiated twice. All other logic stays inline.

Verification
REQ-036 Impulse: in_data=1 then 1023 zeros, gapless.
- Required: out_data[k] = coefficient k sign-extended (first 32'hFFFFFF9E), then zeros.
- Required: exactly 1055 out_valid pulses; frame_done on the 1055th.
REQ-037 in_valid toggling 1,0,1,0 with a random signal:
- Required: 1055 outputs, bit-identical to the gapless run.
- Required: fir_en=0 on every gap cycle.
REQ-038 start pulsed during LOAD and FLUSH -> no effect; a single frame_done.
REQ-039 rst=0 after 500 handshakes:
- Required: next cycle busy=0, in_ready=0, out_valid=0.
- Required: a new start runs a clean impulse frame identical to REQ-036.
REQ-040 Back-to-back frames (start in the cycle after frame_done):
- Required: the second impulse frame output matches the first, with no residue from frame 1.
REQ-041 FRAME_LEN=4, TAPS=32, inputs 1,2,3,4 -> exactly 35 outputs; FLUSH lasts exactly 32 cycles.

Source files
------------

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared definitions for the FIR frame controller and the FIR
//               datapath it feeds. Holds the controller state encoding, the
//               default frame/filter geometry, and the 32-entry coefficient
//               table used by the FIR datapath.
//               Contents:
//                 c_st_*          - controller state encoding (2 bits)
//                 c_*_def         - default FRAME_LEN / TAPS / DW / OW
//                 c_coefs         - 32 signed 16-bit tap coefficients
//                 coef()          - bounded coefficient lookup
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

  // Controller state encoding
  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_load  = 2'd1;
  localparam logic [1:0] c_st_flush = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  // Default geometry
  localparam int c_frame_len_def = 1024;
  localparam int c_taps_def      = 32;
  localparam int c_dw_def        = 16;
  localparam int c_ow_def        = 32;

  // Tap coefficients, tap 0 applies to the newest sample.
  localparam int c_coef_n = 32;
  localparam logic signed [15:0] c_coefs [0:c_coef_n-1] = '{
    -16'sd98,  -16'sd120, -16'sd85,  -16'sd20,
     16'sd60,   16'sd140,  16'sd190,  16'sd170,
     16'sd60,  -16'sd130, -16'sd340, -16'sd470,
    -16'sd420, -16'sd90,   16'sd520,  16'sd1330,
     16'sd2150, 16'sd2780, 16'sd3010, 16'sd2780,
     16'sd2150, 16'sd1330, 16'sd520, -16'sd90,
    -16'sd420, -16'sd470, -16'sd340, -16'sd130,
     16'sd60,   16'sd170,  16'sd190,  16'sd140
  };

  // Coefficient lookup; taps beyond the table read as zero.
  function automatic logic signed [15:0] coef(input int idx);
    if ((idx >= 0) && (idx < c_coef_n)) begin
      return c_coefs[idx[4:0]];
    end
    return '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter.sv
`default_nettype none
// ============================================================================
// Module      : counter
// Description : Saturating up-counter with synchronous clear. Used by the
//               FIR frame controller for both the sample count and the
//               flush count. The count holds at MAX instead of wrapping, so
//               a missed clear can never alias back to a low count.
// Ports       : clk   - clock, rising edge
//               rst   - synchronous active-low reset
//               clr   - synchronous clear (priority over inc)
//               inc   - increment request
//               count - current count, WIDTH bits
// Revision    : 1.0 - initial release
// ============================================================================
module counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != c_max)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fir_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fir_frame_ctrl
// Description : Frame controller for an external FIR datapath. On start it
//               accepts FRAME_LEN samples (stalling on in_valid gaps), then
//               pushes TAPS zeros through the FIR to drain it. Every shift
//               except the last flush shift yields one registered result two
//               cycles later, so a frame produces FRAME_LEN+TAPS-1 results
//               and leaves the FIR register all-zero for the next frame.
// Ports       : clk        - clock, rising edge
//               rst        - synchronous active-low reset
//               start      - frame start pulse (honoured in IDLE only)
//               in_data    - source sample (signed, DW)
//               in_valid   - source sample valid
//               in_ready   - controller accepts a sample (LOAD)
//               fir_data   - sample to FIR shift register (signed, DW)
//               fir_en     - FIR shift enable
//               fir_d      - FIR combinational sum (signed, OW)
//               out_data   - registered filter result (signed, OW)
//               out_valid  - out_data valid
//               busy       - frame in progress
//               frame_done - one-cycle end-of-frame pulse
// Revision    : 1.0 - initial release
// ============================================================================
module fir_frame_ctrl
  import fir_pkg::*;
#(
  parameter int FRAME_LEN = c_frame_len_def,
  parameter int TAPS      = c_taps_def,
  parameter int DW        = c_dw_def,
  parameter int OW        = c_ow_def
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [DW-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic signed [DW-1:0] fir_data,
  output logic                 fir_en,
  input  logic signed [OW-1:0] fir_d,
  output logic signed [OW-1:0] out_data,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 frame_done
);

  // Counter widths cover 0..N-1; a range of one still needs one bit.
  localparam int c_samp_w  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int c_flush_w = (TAPS > 1) ? $clog2(TAPS) : 1;

  localparam logic [c_samp_w-1:0]  c_samp_last  = c_samp_w'(FRAME_LEN - 1);
  localparam logic [c_flush_w-1:0] c_flush_last = c_flush_w'(TAPS - 1);

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic                 w_in_load;
  logic                 w_in_flush;
  logic                 w_hs;
  logic                 w_last_sample;
  logic                 w_flush_last;
  logic                 w_samp_clr;
  logic                 w_flush_clr;
  logic [c_samp_w-1:0]  w_samp_cnt;
  logic [c_flush_w-1:0] w_flush_cnt;
  logic                 w_emit;
  logic                 r_emit_d1;
  logic                 r_out_valid;
  logic signed [OW-1:0] r_out_data;

  assign w_in_load  = (r_state == c_st_load);
  assign w_in_flush = (r_state == c_st_flush);

  // Handshake and phase-end detection
  assign w_hs          = w_in_load & in_valid;
  assign w_last_sample = w_hs & (w_samp_cnt == c_samp_last);
  assign w_flush_last  = w_in_flush & (w_flush_cnt == c_flush_last);

  // Each counter is cleared outside its own state and on the edge that
  // leaves that state, so it is always zero when the state is re-entered.
  assign w_samp_clr  = ~w_in_load | w_last_sample;
  assign w_flush_clr = ~w_in_flush | w_flush_last;

  counter #(
    .WIDTH (c_samp_w),
    .MAX   (FRAME_LEN - 1)
  ) u_samp_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_samp_clr),
    .inc   (w_hs),
    .count (w_samp_cnt)
  );

  counter #(
    .WIDTH (c_flush_w),
    .MAX   (TAPS - 1)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_flush_clr),
    .inc   (w_in_flush),
    .count (w_flush_cnt)
  );

  // State machine
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (start)         w_state_nxt = c_st_load;
      c_st_load:  if (w_last_sample) w_state_nxt = c_st_flush;
      c_st_flush: if (w_flush_last)  w_state_nxt = c_st_done;
      c_st_done:                     w_state_nxt = c_st_idle;
      default:                       w_state_nxt = c_st_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FIR drive: pass samples through in LOAD, push zeros in FLUSH.
  assign in_ready = w_in_load;
  assign fir_en   = w_hs | w_in_flush;
  assign fir_data = w_in_load ? in_data : '0;

  // The final flush shift only clears the FIR register; its result is not
  // part of the frame, so it is not flagged for output.
  assign w_emit = fir_en & (w_in_load | (w_in_flush & (w_flush_cnt < c_flush_last)));

  // Two-stage result pipeline: the shift lands at the end of the emit cycle,
  // the FIR sum settles in the following cycle and is captured at its end.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_emit_d1   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_emit_d1   <= w_emit;
      r_out_valid <= r_emit_d1;
      if (r_emit_d1) begin
        r_out_data <= fir_d;
      end
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign busy       = (r_state != c_st_idle);
  // DONE is entered exactly two cycles after the last emitted flush shift,
  // which lines this pulse up with the final out_valid.
  assign frame_done = (r_state == c_st_done);

endmodule
`default_nettype wire

// File: tb/tb_fir_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_frame_ctrl
// Description : Self-checking bench for fir_frame_ctrl. Emulates the external
//               FIR datapath, predicts every frame's results as a plain
//               convolution of the accepted samples with the coefficient
//               table, and checks the DUT outputs against that prediction on
//               every cycle. A second instance with FRAME_LEN=4 covers the
//               short-frame case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_frame_ctrl;
  import fir_pkg::*;

  localparam int FL   = 1024;
  localparam int T    = 32;
  localparam int FL4  = 4;
  localparam int NOUT = FL + T - 1;

  typedef struct {
    int v;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic               start, in_valid, in_ready, fir_en, out_valid, busy, frame_done;
  logic signed [15:0] in_data, fir_data;
  logic signed [31:0] fir_d, out_data;

  logic               start4, in_valid4, in_ready4, fir_en4, out_valid4, busy4, frame_done4;
  logic signed [15:0] in_data4, fir_data4;
  logic signed [31:0] fir_d4, out_data4;

  fir_frame_ctrl #(.FRAME_LEN(FL), .TAPS(T), .DW(16), .OW(32)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .fir_data(fir_data), .fir_en(fir_en), .fir_d(fir_d),
    .out_data(out_data), .out_valid(out_valid), .busy(busy), .frame_done(frame_done)
  );

  fir_frame_ctrl #(.FRAME_LEN(FL4), .TAPS(T), .DW(16), .OW(32)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .fir_data(fir_data4), .fir_en(fir_en4), .fir_d(fir_d4),
    .out_data(out_data4), .out_valid(out_valid4), .busy(busy4), .frame_done(frame_done4)
  );

  // ---------------- external FIR datapath emulation ----------------
  logic signed [15:0] fir_reg  [T];
  logic signed [15:0] fir_reg4 [T];

  function automatic int fir_sum(input logic signed [15:0] r [T]);
    int acc = 0;
    for (int i = 0; i < T; i++) acc += int'(coef(i)) * int'(r[i]);
    return acc;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < T; i++) fir_reg[i] <= '0;
    end else if (fir_en) begin
      for (int i = T - 1; i > 0; i--) fir_reg[i] <= fir_reg[i-1];
      fir_reg[0] <= fir_data;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < T; i++) fir_reg4[i] <= '0;
    end else if (fir_en4) begin
      for (int i = T - 1; i > 0; i--) fir_reg4[i] <= fir_reg4[i-1];
      fir_reg4[0] <= fir_data4;
    end
  end

  always_comb fir_d  = fir_sum(fir_reg);
  always_comb fir_d4 = fir_sum(fir_reg4);

  // ---------------- reference model and bookkeeping ----------------
  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  logic signed [15:0] xa [FL];
  exp_t exp_q[$];
  exp_t exp4_q[$];
  int   n_out, done_idx, n_out4, done_idx4;
  logic [31:0] cap  [NOUT];
  logic [31:0] gold [NOUT];
  logic [31:0] cap4 [NOUT];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame result = full convolution of the accepted samples with the taps.
  task automatic build_expected(input int flen, input bit sel);
    exp_t e;
    for (int n = 0; n < flen + T - 1; n++) begin
      int acc;
      acc = 0;
      for (int k = 0; k < T; k++)
        if ((n - k >= 0) && (n - k < flen)) acc += int'(coef(k)) * int'(xa[n-k]);
      e.v    = acc;
      e.last = (n == flen + T - 2);
      if (sel) exp4_q.push_back(e);
      else     exp_q.push_back(e);
    end
  endtask

  task automatic set_impulse();
    for (int i = 0; i < FL; i++) xa[i] = '0;
    xa[0] = 16'sd1;
  endtask

  task automatic set_random();
    for (int i = 0; i < FL; i++) xa[i] = 16'($urandom);
  endtask

  // ---------------- compare process ----------------
  initial begin
    exp_t ce;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (in_ready && !in_valid) chk("gap_fir_en", fir_en, 0);
        if (out_valid) begin
          if (exp_q.size() == 0) chk("spurious_out_valid", out_valid, 0);
          else begin
            ce = exp_q.pop_front();
            chk("out_data", out_data, ce.v);
            chk("done_on_last", frame_done, ce.last);
            if (n_out < NOUT) cap[n_out] = out_data;
            n_out++;
            if (frame_done) done_idx = n_out;
          end
        end else chk("done_without_valid", frame_done, 0);

        if (in_ready4 && !in_valid4) chk("gap_fir_en4", fir_en4, 0);
        if (out_valid4) begin
          if (exp4_q.size() == 0) chk("spurious_out_valid4", out_valid4, 0);
          else begin
            ce = exp4_q.pop_front();
            chk("out_data4", out_data4, ce.v);
            chk("done_on_last4", frame_done4, ce.last);
            if (n_out4 < NOUT) cap4[n_out4] = out_data4;
            n_out4++;
            if (frame_done4) done_idx4 = n_out4;
          end
        end else chk("done_without_valid4", frame_done4, 0);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fir_en", fir_en, 0);
    repeat (40) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge with the DUT in IDLE; returns just after
  // the rising edge that follows DONE (DUT in IDLE again).
  task automatic drive_frame(input int gap_mode, input int abort_at, input bit poke);
    int idx, cyc, flush_cyc;
    bit hs, done;
    n_out = 0; done_idx = 0;
    build_expected(FL, 1'b0);
    start = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; cyc = 0;
    while (idx < FL && cyc < FL * 4) begin
      if (idx == abort_at) begin
        do_reset();
        return;
      end
      in_valid = (gap_mode == 0) || (gap_mode == 1 && cyc % 2 == 0) ||
                 (gap_mode == 2 && $urandom_range(0, 9) < 7);
      in_data  = in_valid ? xa[idx] : 16'($urandom);
      start    = poke && (cyc % 37 == 5);
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0;
    if (idx < FL) begin
      chk("load_timeout", idx, FL);
      do_reset();
      return;
    end
    flush_cyc = 0; done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (frame_done) done = 1'b1;
      else begin
        if (busy && !in_ready) flush_cyc++;
        @(posedge clk); #1;
        start = poke && (i % 5 == 1);
      end
    end
    chk("frame_done_seen", done, 1);
    chk("flush_len", flush_cyc, T);
    chk("queue_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_vs_gold(input string name);
    chk({name, "_count"}, n_out, NOUT);
    for (int i = 0; i < NOUT; i++) chk(name, cap[i], gold[i]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int flush_cyc;
    bit done;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    start4 = 1'b0; in_valid4 = 1'b0; in_data4 = '0;
    n_out = 0; done_idx = 0; n_out4 = 0; done_idx4 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_fir_en", fir_en, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_frame_done", frame_done, 0);
    rst = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Gapless impulse: pins the model against hand-computed values
    set_impulse();
    drive_frame(0, -1, 1'b0);
    chk("imp_count", n_out, 1055);
    chk("imp_done_idx", done_idx, 1055);
    chk("imp_first", cap[0], 32'hFFFFFF9E);
    chk("imp_second", cap[1], 32'hFFFFFF88);
    chk("imp_tap31", cap[31], 32'h0000008C);
    chk("imp_tail_zero", cap[40], 32'h0);
    gold = cap;

    // Impulse with in_valid toggling, random data in the gaps
    set_impulse();
    drive_frame(1, -1, 1'b0);
    check_vs_gold("toggle_vs_gapless");

    // Random data, random gaps, start poked during LOAD and FLUSH
    set_random();
    drive_frame(2, -1, 1'b1);
    chk("poke_count", n_out, NOUT);
    chk("poke_done_idx", done_idx, NOUT);

    // Reset after 500 handshakes, then a clean impulse frame
    set_random();
    drive_frame(2, 500, 1'b0);
    set_impulse();
    drive_frame(0, -1, 1'b0);
    check_vs_gold("post_reset_imp");

    // Back-to-back: random frame immediately followed by an impulse frame
    set_random();
    drive_frame(0, -1, 1'b0);
    set_impulse();
    drive_frame(0, -1, 1'b0);
    check_vs_gold("b2b_imp");

    // Short frame on the FRAME_LEN=4 instance
    for (int i = 0; i < FL; i++) xa[i] = '0;
    for (int i = 0; i < FL4; i++) xa[i] = 16'(i + 1);
    n_out4 = 0; done_idx4 = 0;
    build_expected(FL4, 1'b1);
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int i = 0; i < FL4; i++) begin
      in_valid4 = 1'b1; in_data4 = xa[i];
      @(posedge clk); #1;
    end
    in_valid4 = 1'b0;
    flush_cyc = 0; done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (frame_done4) done = 1'b1;
      else begin
        if (busy4 && !in_ready4) flush_cyc++;
        @(posedge clk); #1;
      end
    end
    chk("short_done_seen", done, 1);
    chk("short_flush_len", flush_cyc, 32);
    chk("short_count", n_out4, 35);
    chk("short_done_idx", done_idx4, 35);
    chk("short_first", cap4[0], 32'hFFFFFF9E);
    chk("short_second", cap4[1], 32'hFFFFFEC4);
    chk("short_last", cap4[34], 32'h00000230);
    repeat (5) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
